decode_stage: RTL

- Decode stage of the pipelined RISC-V core; producer side of the ALU interface.
- Accepts a fetched instruction and PC from fetch through a valid/ready handshake.
- Reads the register file and decodes RV32I OP, OP-IMM, LUI and AUIPC into AluOp plus two operands.
- Registers the result into the decode→execute pipeline register with its own valid/ready handshake.

---
 rtl/decode_stage_pkg.sv | 41 ++++
 rtl/decode_stage_imm_gen.sv | 18 +
 rtl/decode_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode types: ALU op encoding, base opcodes, word type and instruction field split.
package decode_stage_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // Encoding is {funct7[5], funct3} so OP instructions map straight through.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [31:0] instr);
        return instr_fields_t'(instr);
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// I/U immediate and shift-amount extraction from the upper instruction bits.
// Purely combinational; no handshake.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:12]     instr_hi,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] shamt
);

    assign imm_i = {{(XLEN-12){instr_hi[31]}}, instr_hi[31:20]};
    assign imm_u = XLEN'(signed'({instr_hi, 12'b0}));
    assign shamt = XLEN'(instr_hi[24:20]);

endmodule

// File: rtl/decode_stage.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode into an ALU payload register; 1-cycle latency, in_ready = !out_valid || out_ready.
// Payload holds under backpressure; flush kills it. DECODE_PERF_EN adds handshake/illegal counters.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            illegal,
    output logic [XLEN-1:0] pc_out
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_illegal
`endif
);

    typedef struct packed {
        alu_op_e         alu_op;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [4:0]      rd;
        logic            reg_write;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } payload_t;

    instr_fields_t   f;
    logic [XLEN-1:0] imm_i, imm_u, shamt;
    logic            accept;
    logic            legal;
    payload_t        nxt, q;

    assign f        = split_instr(in_instr);
    assign rs1_addr = f.rs1;
    assign rs2_addr = f.rs2;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_hi (in_instr[31:12]),
        .imm_i    (imm_i),
        .imm_u    (imm_u),
        .shamt    (shamt)
    );

    always_comb begin
        legal         = 1'b0;
        nxt.alu_op    = ALU_ADD;
        nxt.op_a      = '0;
        nxt.op_b      = '0;
        nxt.rd        = f.rd;
        nxt.pc        = in_pc;
        case (f.opcode)
            OPC_OP: begin
                legal = (f.funct7 == 7'b0000000) ||
                        (f.funct7 == 7'b0100000 && (f.funct3 == 3'b000 || f.funct3 == 3'b101));
                nxt.alu_op = alu_op_e'({f.funct7[5], f.funct3});
                nxt.op_a   = rs1_data;
                // Register shifts only honour the low five bits of rs2.
                nxt.op_b   = (f.funct3 == 3'b001 || f.funct3 == 3'b101) ? XLEN'(rs2_data[4:0]) : rs2_data;
            end
            OPC_OP_IMM: begin
                nxt.op_a = rs1_data;
                case (f.funct3)
                    3'b001: begin
                        legal      = (f.funct7 == 7'b0000000);
                        nxt.alu_op = ALU_SLL;
                        nxt.op_b   = shamt;
                    end
                    3'b101: begin
                        legal      = (f.funct7 == 7'b0000000) || (f.funct7 == 7'b0100000);
                        nxt.alu_op = alu_op_e'({f.funct7[5], 3'b101});
                        nxt.op_b   = shamt;
                    end
                    default: begin
                        legal      = 1'b1;
                        nxt.alu_op = alu_op_e'({1'b0, f.funct3});
                        nxt.op_b   = imm_i;
                    end
                endcase
            end
            OPC_LUI: begin
                legal    = 1'b1;
                nxt.op_b = imm_u;
            end
            OPC_AUIPC: begin
                legal    = 1'b1;
                nxt.op_a = in_pc;
                nxt.op_b = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            nxt.alu_op = ALU_ADD;
            nxt.op_a   = '0;
            nxt.op_b   = '0;
        end
        nxt.illegal   = !legal;
        nxt.reg_write = legal && (f.rd != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            q.alu_op    <= ALU_ADD;
            q.op_a      <= '0;
            q.op_b      <= '0;
            q.rd        <= '0;
            q.reg_write <= 1'b0;
            q.illegal   <= 1'b0;
            q.pc        <= RESET_PC;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                q         <= nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign alu_op    = q.alu_op;
    assign op_a      = q.op_a;
    assign op_b      = q.op_b;
    assign rd        = q.rd;
    assign reg_write = q.reg_write;
    assign illegal   = q.illegal;
    assign pc_out    = q.pc;

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded <= '0;
            perf_illegal <= '0;
        end else if (out_valid && out_ready) begin
            perf_decoded <= perf_decoded + 32'd1;
            if (q.illegal) begin
                perf_illegal <= perf_illegal + 32'd1;
            end
        end
    end
`endif

endmodule
